mac_layer_engine: RTL and testbench

Parametrised successor to the layer-1 MAC stage. It computes LANES neuron outputs in parallel, each as a signed fixed-point dot product of length N_IN. The input sample is broadcast to all lanes, and each lane receives its own weight. Results are rescaled and saturated, with an optional ReLU and a valid/ready output handshake. It sits between the input/weight SRAM readers and the activation/RouteData path, and replaces the fixed 160-lane, reset-cleared accumulator with start/done sequencing and backpressure.

---
 rtl/mac_layer_pkg.sv | 23 ++
 rtl/mac_lane.sv | 42 ++++
 rtl/mac_layer_engine.sv | 79 +++++++
 tb/tb_mac_layer_engine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mac_layer_pkg.sv
// mac_layer_pkg: shared state encoding, default widths and the output rescale/saturate helper.
package mac_layer_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT_LOAD, OUTPUT_HOLD} state_t;
   localparam int DEF_DW = 16;
   localparam int DEF_FRAC = 8;
   localparam int SAT_W = 64;
   typedef struct packed {
      logic sat;
      logic [SAT_W-1:0] word;
   } sat_res_t;
   function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc, input logic relu,
                                          input int dw, input int frac);
      logic signed [SAT_W-1:0] s, hi, lo, w;
      sat_res_t r;
      s = acc >>> frac;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      w = (s > hi) ? hi : (s < lo) ? lo : s;
      r.sat = (s > hi) || (s < lo);
      r.word = (relu && w[SAT_W-1]) ? '0 : w;
      return r;
   endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one neuron -- signed multiply-accumulate plus registered rescale/saturate/ReLU result.
module mac_lane
   import mac_layer_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int FRAC = DEF_FRAC,
   parameter int ACC_W = 40
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 load,
   input  logic                 relu,
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] w,
   output logic        [DW-1:0] q,
   output logic                 sat
);
   logic signed [ACC_W-1:0] acc;
   logic signed [2*DW-1:0] prod;
   sat_res_t res;
   logic [SAT_W-DW-1:0] word_unused;
   logic [DW-1:0] word;
   assign prod = x * w;
   assign res = sat_shift(SAT_W'(acc), relu, DW, FRAC);
   assign {word_unused, word} = res.word;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         q <= '0;
         sat <= 1'b0;
      end else begin
         if (clr) acc <= '0;
         else if (en) acc <= acc + ACC_W'(prod);
         if (load) begin
            q <= word;
            sat <= res.sat;
         end
      end
   end
endmodule

// File: rtl/mac_layer_engine.sv
// mac_layer_engine: LANES parallel fixed-point dot products of length N_IN with start/done
// sequencing, input valid/ready and a held output valid/ready handshake.
module mac_layer_engine
   import mac_layer_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int FRAC = DEF_FRAC,
   parameter int LANES = 10,
   parameter int N_IN = 160,
   parameter int ACC_W = 40
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  relu_en,
   output logic                  busy,
   output logic                  done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DW-1:0]         in_x,
   input  logic [LANES*DW-1:0]   in_w,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*DW-1:0]   out_data,
   output logic [LANES-1:0]      sat_flag
);
   localparam int CW = N_IN > 1 ? $clog2(N_IN) : 1;
   if (ACC_W < 2*DW + $clog2(N_IN) || ACC_W > SAT_W) begin : g_acc_check
      $fatal(1, "mac_layer_engine: ACC_W must cover 2*DW+clog2(N_IN) and not exceed SAT_W");
   end
   state_t state, state_n;
   logic [CW-1:0] count;
   logic relu_q, fire, last, clr;
   assign in_ready = state == ACCUM;
   assign busy = state != IDLE;
   assign out_valid = state == OUTPUT_HOLD;
   assign fire = in_valid && in_ready;
   assign last = count == CW'(N_IN - 1);
   assign clr = state == IDLE && start;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:        if (start) state_n = ACCUM;
         ACCUM:       if (fire && last) state_n = OUTPUT_LOAD;
         OUTPUT_LOAD: state_n = OUTPUT_HOLD;
         OUTPUT_HOLD: if (out_ready) state_n = IDLE;
         default:     state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
         relu_q <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         done <= out_valid && out_ready;
         if (clr) begin
            count <= '0;
            relu_q <= relu_en;
         end else if (fire) count <= count + CW'(1);
      end
   end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mac_lane #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
         .clk  (clk),
         .reset(reset),
         .clr  (clr),
         .en   (fire),
         .load (state == OUTPUT_LOAD),
         .relu (relu_q),
         .x    (in_x),
         .w    (in_w[i*DW +: DW]),
         .q    (out_data[i*DW +: DW]),
         .sat  (sat_flag[i])
      );
   end
endmodule

// File: tb/tb_mac_layer_engine.sv
// tb_mac_layer_engine: directed vectors on a 2-lane, 4-input engine and a 2-lane, 1-input engine.
module tb_mac_layer_engine;
   localparam int DW = 16;
   localparam int LANES = 2;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   logic start, relu_en, in_valid, out_ready, busy, done, in_ready, out_valid;
   logic [DW-1:0] in_x;
   logic [LANES*DW-1:0] in_w, out_data;
   logic [LANES-1:0] sat_flag;
   logic r_start, r_relu_en, r_in_valid, r_out_ready, r_busy, r_done, r_in_ready, r_out_valid;
   logic [DW-1:0] r_in_x;
   logic [LANES*DW-1:0] r_in_w, r_out_data;
   logic [LANES-1:0] r_sat_flag;
   int n_vec = 0;
   int n_bad = 0;

   mac_layer_engine #(.DW(DW), .FRAC(8), .LANES(LANES), .N_IN(4), .ACC_W(40)) dut (
      .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sat_flag(sat_flag)
   );
   mac_layer_engine #(.DW(DW), .FRAC(8), .LANES(LANES), .N_IN(1), .ACC_W(32)) dut_r (
      .clk(clk), .reset(reset), .start(r_start), .relu_en(r_relu_en), .busy(r_busy), .done(r_done),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_x(r_in_x), .in_w(r_in_w),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data), .sat_flag(r_sat_flag)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_pass(input logic r);
      start = 1'b1;
      relu_en = r;
      tick;
      start = 1'b0;
      relu_en = 1'b0;
   endtask

   task automatic push(input logic [15:0] x, input logic [31:0] w);
      in_valid = 1'b1;
      in_x = x;
      in_w = w;
      tick;
      in_valid = 1'b0;
   endtask

   task automatic finish_out(input string tag, input logic [31:0] d, input logic [1:0] s, input int hold);
      check({tag, "_lat1"}, out_valid, 0);
      tick;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, d);
      check({tag, "_sat"}, sat_flag, s);
      for (int k = 0; k < hold; k++) begin
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_data"}, out_data, d);
         check({tag, "_hold_done"}, done, 0);
         tick;
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_data_kept"}, out_data, d);
      tick;
      check({tag, "_done_pulse"}, done, 0);
   endtask

   task automatic r_pass(input string tag, input logic r, input logic [15:0] x, input logic [31:0] w,
                         input logic [31:0] d, input logic [1:0] s);
      r_start = 1'b1;
      r_relu_en = r;
      tick;
      r_start = 1'b0;
      r_relu_en = 1'b0;
      r_in_valid = 1'b1;
      r_in_x = x;
      r_in_w = w;
      tick;
      r_in_valid = 1'b0;
      check({tag, "_lat1"}, r_out_valid, 0);
      tick;
      check({tag, "_valid"}, r_out_valid, 1);
      check({tag, "_data"}, r_out_data, d);
      check({tag, "_sat"}, r_sat_flag, s);
      r_out_ready = 1'b1;
      tick;
      r_out_ready = 1'b0;
      check({tag, "_done"}, r_done, 1);
   endtask

   initial begin
      logic [6:0] gaps;
      {start, relu_en, in_valid, out_ready, in_x, in_w} = '0;
      {r_start, r_relu_en, r_in_valid, r_out_ready, r_in_x, r_in_w} = '0;
      tick;
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_data", out_data, 0);
      check("rst_sat", sat_flag, 0);
      reset = 1'b1;
      in_valid = 1'b1;
      in_x = 16'h7FFF;
      in_w = 32'h7FFF_7FFF;
      tick;
      check("idle_ready", in_ready, 0);
      in_valid = 1'b0;
      // basic pass: idle operands above must not have been summed in
      begin_pass(1'b0);
      check("accum_ready", in_ready, 1);
      check("accum_busy", busy, 1);
      repeat (4) push(16'h0100, 32'hFF00_0200);
      finish_out("basic", 32'hFC00_0800, 2'b00, 0);
      begin_pass(1'b0);
      repeat (4) push(16'h7FFF, 32'h8000_7FFF);
      finish_out("sat", 32'h8000_7FFF, 2'b11, 0);
      // -4 >>> 8 rounds toward -inf to -1; +4 >>> 8 gives 0; held off by backpressure
      begin_pass(1'b0);
      repeat (4) push(16'h0001, 32'h0001_FFFF);
      finish_out("bp", 32'h0000_FFFF, 2'b00, 5);
      begin_pass(1'b0);
      gaps = 7'b1011001;
      for (int k = 0; k < 7; k++) begin
         in_valid = gaps[k];
         in_x = gaps[k] ? 16'h0100 : 16'h7FFF;
         in_w = gaps[k] ? 32'h0100_0080 : 32'h7FFF_7FFF;
         start = (k == 1);
         if (k == 6) check("gap_still_accum", in_ready, 1);
         tick;
      end
      in_valid = 1'b0;
      start = 1'b0;
      finish_out("gap", 32'h0400_0200, 2'b00, 0);
      begin_pass(1'b0);
      repeat (2) push(16'h0200, 32'h0100_0100);
      reset = 1'b0;
      #1;
      check("arst_ready", in_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_valid", out_valid, 0);
      check("arst_done", done, 0);
      #3;
      reset = 1'b1;
      tick;
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      begin_pass(1'b0);
      repeat (4) push(16'h0100, 32'h0300_0100);
      finish_out("after_rst", 32'h0C00_0400, 2'b00, 0);
      r_pass("relu_off", 1'b0, 16'h0100, 32'h0100_FF80, 32'h0100_FF80, 2'b00);
      r_pass("relu_on", 1'b1, 16'h0100, 32'h0100_FF80, 32'h0100_0000, 2'b00);
      r_pass("relu_negclip", 1'b1, 16'h7FFF, 32'h0100_8000, 32'h7FFF_0000, 2'b01);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
